// File: rtl/rx_demux_if.sv
// rx_demux_if: one 64-bit AXI4-Stream link as used on the PCIe RX side.
//   tdata  [63:0] beat payload
//   tkeep  [7:0]  byte enables
//   tlast         end of TLP
//   tvalid        beat valid
//   tuser  [21:0] core sideband, carried through untouched
//   tready        sink accepts the beat when tvalid & tready
// master: drives the payload and tvalid, samples tready.
// slave : samples the payload and tvalid, drives tready.
interface rx_demux_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic [21:0] tuser;
    logic        tready;

    modport master (
        output tdata, tkeep, tlast, tvalid, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tvalid, tuser,
        output tready
    );
endinterface

// File: rtl/rx_demux.sv
// rx_demux: steers whole TLPs from the single PCIe RX stream to one of two
// consumers.
//   port 1 (m_axis_rx1): requester/target traffic (MRd/MWr/IO/Cfg), and
//                        message TLPs when ROUTE_MSG=1.
//   port 2 (m_axis_rx2): completions (Cpl/CplD/CplLk/CplDLk).
// Message TLPs are swallowed and counted when ROUTE_MSG=0.
// The route is decided from DW0 of the first beat and held to tlast. Each
// output port has a single register stage, so an accepted beat shows up on
// its port one clock later.
// Ports:
//   clk        core user clock
//   sys_rst_n  asynchronous active-low reset
//   m_axis_rx  incoming RX stream (slave side)
//   m_axis_rx1 port 1 output stream (master side)
//   m_axis_rx2 port 2 output stream (master side)
//   drop_cnt   saturating count of discarded TLPs
//   in_pkt     high while inside a multi-beat TLP (after first, before tlast)
module rx_demux #(
    parameter int DROP_CNT_W = 16,
    parameter int ROUTE_MSG  = 0
) (
    input  logic                  clk,
    input  logic                  sys_rst_n,
    rx_demux_if.slave             m_axis_rx,
    rx_demux_if.master            m_axis_rx1,
    rx_demux_if.master            m_axis_rx2,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  in_pkt
);

    typedef enum logic [1:0] {
        ROUTE_DROP = 2'd0,
        ROUTE_P1   = 2'd1,
        ROUTE_P2   = 2'd2
    } route_t;

    typedef enum logic {
        ST_SOP  = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t state_q, state_d;
    route_t route_q, route_d;
    route_t route_hdr;
    route_t route_sel;

    logic [4:0] hdr_type;
    logic       can_load1, can_load2;
    logic       accept, load1, load2, drop_first;

    logic        valid1_q, valid2_q;
    logic [63:0] data1_q, data2_q;
    logic [7:0]  keep1_q, keep2_q;
    logic        last1_q, last2_q;
    logic [21:0] user1_q, user2_q;

    logic [DROP_CNT_W-1:0] drop_cnt_q;

    assign hdr_type = m_axis_rx.tdata[28:24];

    // Classification of the current beat as if it were a first beat. Only
    // consulted while in SOP; later beats never influence the route.
    always_comb begin
        route_hdr = ROUTE_P1;
        if (hdr_type[4:1] == 4'b0101) begin
            route_hdr = ROUTE_P2;
        end else if (hdr_type[4:3] == 2'b10) begin
            route_hdr = (ROUTE_MSG != 0) ? ROUTE_P1 : ROUTE_DROP;
        end
    end

    assign route_sel = (state_q == ST_SOP) ? route_hdr : route_q;

    // A port can take a new beat when it is empty or its current beat is
    // leaving this cycle, which gives full throughput with ready held high.
    assign can_load1 = ~valid1_q | m_axis_rx1.tready;
    assign can_load2 = ~valid2_q | m_axis_rx2.tready;

    // Input ready follows only the selected consumer, so a stalled port never
    // blocks traffic bound for the other one. Dropped beats are always taken.
    always_comb begin
        m_axis_rx.tready = 1'b0;
        case (route_sel)
            ROUTE_DROP: m_axis_rx.tready = 1'b1;
            ROUTE_P1:   m_axis_rx.tready = can_load1;
            ROUTE_P2:   m_axis_rx.tready = can_load2;
            default:    m_axis_rx.tready = 1'b0;
        endcase
    end

    assign accept     = m_axis_rx.tvalid & m_axis_rx.tready;
    assign load1      = accept & (route_sel == ROUTE_P1);
    assign load2      = accept & (route_sel == ROUTE_P2);
    assign drop_first = accept & (state_q == ST_SOP) & (route_hdr == ROUTE_DROP);

    // Packet framing: the route is captured on the first accepted beat and
    // held until the tlast beat returns the machine to SOP. Idle gaps inside
    // a packet leave both state and route untouched.
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        if (accept) begin
            case (state_q)
                ST_SOP: begin
                    route_d = route_hdr;
                    state_d = m_axis_rx.tlast ? ST_SOP : ST_BODY;
                end
                ST_BODY: begin
                    if (m_axis_rx.tlast) begin
                        state_d = ST_SOP;
                    end
                end
                default: state_d = ST_SOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_SOP;
            route_q <= ROUTE_P1;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    // Dropped TLPs are counted once, on their first beat; the counter sticks
    // at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop_first && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    // Port 1 output register. The payload only changes on a load, so it stays
    // stable while valid is waiting for ready.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            valid1_q <= 1'b0;
            data1_q  <= '0;
            keep1_q  <= '0;
            last1_q  <= 1'b0;
            user1_q  <= '0;
        end else if (load1) begin
            valid1_q <= 1'b1;
            data1_q  <= m_axis_rx.tdata;
            keep1_q  <= m_axis_rx.tkeep;
            last1_q  <= m_axis_rx.tlast;
            user1_q  <= m_axis_rx.tuser;
        end else if (m_axis_rx1.tready) begin
            valid1_q <= 1'b0;
        end
    end

    // Port 2 output register; drains independently of whatever port 1 and
    // the input are doing.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            valid2_q <= 1'b0;
            data2_q  <= '0;
            keep2_q  <= '0;
            last2_q  <= 1'b0;
            user2_q  <= '0;
        end else if (load2) begin
            valid2_q <= 1'b1;
            data2_q  <= m_axis_rx.tdata;
            keep2_q  <= m_axis_rx.tkeep;
            last2_q  <= m_axis_rx.tlast;
            user2_q  <= m_axis_rx.tuser;
        end else if (m_axis_rx2.tready) begin
            valid2_q <= 1'b0;
        end
    end

    assign m_axis_rx1.tvalid = valid1_q;
    assign m_axis_rx1.tdata  = data1_q;
    assign m_axis_rx1.tkeep  = keep1_q;
    assign m_axis_rx1.tlast  = last1_q;
    assign m_axis_rx1.tuser  = user1_q;

    assign m_axis_rx2.tvalid = valid2_q;
    assign m_axis_rx2.tdata  = data2_q;
    assign m_axis_rx2.tkeep  = keep2_q;
    assign m_axis_rx2.tlast  = last2_q;
    assign m_axis_rx2.tuser  = user2_q;

    assign drop_cnt = drop_cnt_q;
    assign in_pkt   = (state_q == ST_BODY);

endmodule

// File: tb/tb_rx_demux.sv
// tb_rx_demux: scoreboard bench for rx_demux.
// dut_a runs with ROUTE_MSG=0 (messages dropped) and carries most of the
// directed traffic; dut_b runs with ROUTE_MSG=1 to show messages reaching
// port 1. Stimulus pushes each beat's expected image onto the queue of the
// port it must come out of; a negedge monitor pops and compares on every
// output handshake and also checks that a stalled beat stays put.
module tb_rx_demux;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [21:0] user;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        rdy1_a, rdy2_a;
    logic        rdy1_b, rdy2_b;
    logic [15:0] drop_cnt_a, drop_cnt_b;
    logic        in_pkt_a, in_pkt_b;

    int          checks;
    int          errors;
    logic [15:0] exp_drop;

    // queue index: 0 = dut_a port 1, 1 = dut_a port 2, 2 = dut_b port 1, 3 = dut_b port 2
    beat_t exp_q[4][$];
    logic  hold[4];
    beat_t held[4];

    rx_demux_if in_a ();
    rx_demux_if p1_a ();
    rx_demux_if p2_a ();
    rx_demux_if in_b ();
    rx_demux_if p1_b ();
    rx_demux_if p2_b ();

    assign p1_a.tready = rdy1_a;
    assign p2_a.tready = rdy2_a;
    assign p1_b.tready = rdy1_b;
    assign p2_b.tready = rdy2_b;

    rx_demux #(.DROP_CNT_W(16), .ROUTE_MSG(0)) dut_a (
        .clk        (clk),
        .sys_rst_n  (rst_n),
        .m_axis_rx  (in_a),
        .m_axis_rx1 (p1_a),
        .m_axis_rx2 (p2_a),
        .drop_cnt   (drop_cnt_a),
        .in_pkt     (in_pkt_a)
    );

    rx_demux #(.DROP_CNT_W(16), .ROUTE_MSG(1)) dut_b (
        .clk        (clk),
        .sys_rst_n  (rst_n),
        .m_axis_rx  (in_b),
        .m_axis_rx1 (p1_b),
        .m_axis_rx2 (p2_b),
        .drop_cnt   (drop_cnt_b),
        .in_pkt     (in_pkt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One output port: compare on handshake, insist on stability while stalled.
    task automatic mon_port(input int id, input string nm, input logic valid,
                            input logic ready, input beat_t cur);
        if (valid) begin
            if (hold[id]) check({nm, "_stable"}, cur, held[id]);
            if (ready) begin
                if (exp_q[id].size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s_unexpected: got beat %h, expected none", nm, cur);
                end else begin
                    check(nm, cur, exp_q[id].pop_front());
                end
                hold[id] = 1'b0;
            end else begin
                hold[id] = 1'b1;
                held[id] = cur;
            end
        end else begin
            if (hold[id]) check({nm, "_valid_held"}, {95'd0, valid}, 96'd1);
            hold[id] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hold[i] = 1'b0;
        end else begin
            mon_port(0, "p1a", p1_a.tvalid, rdy1_a, {p1_a.tdata, p1_a.tkeep, p1_a.tlast, p1_a.tuser});
            mon_port(1, "p2a", p2_a.tvalid, rdy2_a, {p2_a.tdata, p2_a.tkeep, p2_a.tlast, p2_a.tuser});
            mon_port(2, "p1b", p1_b.tvalid, rdy1_b, {p1_b.tdata, p1_b.tkeep, p1_b.tlast, p1_b.tuser});
            mon_port(3, "p2b", p2_b.tvalid, rdy2_b, {p2_b.tdata, p2_b.tkeep, p2_b.tlast, p2_b.tuser});
        end
    end

    // Present one beat to dut_a; route 0 = dropped, 1 = port 1, 2 = port 2.
    // Returns the number of cycles the beat waited for tready.
    task automatic apply_stimulus(input logic [63:0] d, input logic [7:0] k, input logic l,
                                  input logic [21:0] u, input int route, output int stalls);
        beat_t b;
        logic  taken;
        b = {d, k, l, u};
        in_a.tdata  = d;
        in_a.tkeep  = k;
        in_a.tlast  = l;
        in_a.tuser  = u;
        in_a.tvalid = 1'b1;
        if (route == 1) exp_q[0].push_back(b);
        if (route == 2) exp_q[1].push_back(b);
        stalls = 0;
        taken  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_a.tready) begin
                taken = 1'b1;
                break;
            end
            stalls++;
        end
        checks++;
        if (!taken) begin
            errors++;
            $display("[TB] FAIL accept_timeout: got tready 0 for 100 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        in_a.tvalid = 1'b0;
    endtask

    task automatic send_b(input logic [63:0] d, input logic l, input int route);
        beat_t b;
        b = {d, 8'hFF, l, 22'h0};
        in_b.tdata  = d;
        in_b.tkeep  = 8'hFF;
        in_b.tlast  = l;
        in_b.tuser  = 22'h0;
        in_b.tvalid = 1'b1;
        if (route == 1) exp_q[2].push_back(b);
        if (route == 2) exp_q[3].push_back(b);
        @(negedge clk);
        check("b_tready", {95'd0, in_b.tready}, 96'd1);
        @(posedge clk);
        #1;
        in_b.tvalid = 1'b0;
    endtask

    task automatic count_drop();
        if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    endtask

    int st;

    initial begin
        checks   = 0;
        errors   = 0;
        exp_drop = 16'd0;
        rst_n    = 1'b0;
        rdy1_a = 1'b1; rdy2_a = 1'b1; rdy1_b = 1'b1; rdy2_b = 1'b1;
        in_a.tdata = '0; in_a.tkeep = '0; in_a.tlast = 1'b0; in_a.tuser = '0; in_a.tvalid = 1'b0;
        in_b.tdata = '0; in_b.tkeep = '0; in_b.tlast = 1'b0; in_b.tuser = '0; in_b.tvalid = 1'b0;

        // reset state
        #12;
        check("rst_p1_valid", {95'd0, p1_a.tvalid}, 96'd0);
        check("rst_p2_valid", {95'd0, p2_a.tvalid}, 96'd0);
        check("rst_drop_cnt", {80'd0, drop_cnt_a}, 96'd0);
        check("rst_in_pkt",   {95'd0, in_pkt_a}, 96'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MWr, 3 beats, both consumers ready
        apply_stimulus(64'h0000_1111_4000_0001, 8'hFF, 1'b0, 22'h00_0A1, 1, st);
        check("t1_stall_b1", st, 0);
        check("t1_latency",  {95'd0, p1_a.tvalid}, 96'd1);
        check("t1_in_pkt",   {95'd0, in_pkt_a}, 96'd1);
        apply_stimulus(64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b0, 22'h00_0A2, 1, st);
        check("t1_stall_b2", st, 0);
        apply_stimulus(64'h0BAD_F00D_CAFE_0003, 8'h0F, 1'b1, 22'h00_0A3, 1, st);
        check("t1_stall_b3", st, 0);
        check("t1_in_pkt_end", {95'd0, in_pkt_a}, 96'd0);
        repeat (2) @(posedge clk);
        #1;

        // CplD, 2 beats, port 2 stalled for 4 cycles
        rdy2_a = 1'b0;
        apply_stimulus(64'h0000_2222_4A00_0001, 8'hFF, 1'b0, 22'h00_0B1, 2, st);
        check("t2_stall_b1", st, 0);
        fork
            apply_stimulus(64'h5555_6666_7777_8888, 8'hFF, 1'b1, 22'h00_0B2, 2, st);
            begin
                repeat (4) @(posedge clk);
                #1;
                rdy2_a = 1'b1;
            end
        join
        check("t2_stall_b2", st, 4);
        check("t2_p2_valid", {95'd0, p2_a.tvalid}, 96'd1);
        repeat (2) @(posedge clk);
        #1;

        // message dropped on dut_a, forwarded on dut_b
        apply_stimulus(64'h0000_0000_3400_0000, 8'hFF, 1'b0, 22'h0, 0, st);
        count_drop();
        check("t3_stall_b1", st, 0);
        check("t3_drop_cnt", {80'd0, drop_cnt_a}, {80'd0, exp_drop});
        apply_stimulus(64'h0000_0003_0000_0004, 8'hFF, 1'b1, 22'h0, 0, st);
        check("t3_stall_b2", st, 0);
        check("t3_drop_cnt2", {80'd0, drop_cnt_a}, {80'd0, exp_drop});
        check("t3_p1_idle", {95'd0, p1_a.tvalid}, 96'd0);
        send_b(64'h0000_0000_3400_0000, 1'b0, 1);
        send_b(64'h0000_0003_0000_0004, 1'b1, 1);
        check("t3_b_drop_cnt", {80'd0, drop_cnt_b}, 96'd0);
        repeat (2) @(posedge clk);
        #1;

        // MRd parks on port 1 while a Cpl streams to port 2
        rdy1_a = 1'b0;
        apply_stimulus(64'h0000_0000_0000_0001, 8'h0F, 1'b1, 22'h00_0C1, 1, st);
        check("t4_stall_mrd", st, 0);
        apply_stimulus(64'h0000_3333_0A00_0001, 8'hFF, 1'b0, 22'h00_0C2, 2, st);
        check("t4_stall_cpl1", st, 0);
        apply_stimulus(64'h4444_5555_6666_7777, 8'hFF, 1'b1, 22'h00_0C3, 2, st);
        check("t4_stall_cpl2", st, 0);
        check("t4_p1_parked", {95'd0, p1_a.tvalid}, 96'd1);
        rdy1_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t4_p1_drained", {95'd0, p1_a.tvalid}, 96'd0);

        // header-like body beat must not change the route
        apply_stimulus(64'h0000_0000_4000_0002, 8'hFF, 1'b0, 22'h00_0D1, 1, st);
        apply_stimulus(64'h0000_0000_4A00_0000, 8'hFF, 1'b0, 22'h00_0D2, 1, st);
        apply_stimulus(64'h0000_0000_0000_0D03, 8'hFF, 1'b1, 22'h00_0D3, 1, st);
        repeat (2) @(posedge clk);
        #1;

        // drop counter saturation
        while (exp_drop != 16'hFFFF) begin
            apply_stimulus(64'h0000_0000_3400_0000, 8'hFF, 1'b1, 22'h0, 0, st);
            count_drop();
        end
        check("t5_drop_full", {80'd0, drop_cnt_a}, {80'd0, exp_drop});
        apply_stimulus(64'h0000_0000_3400_0000, 8'hFF, 1'b1, 22'h0, 0, st);
        count_drop();
        check("t5_drop_sat", {80'd0, drop_cnt_a}, {80'd0, exp_drop});

        // reset in the middle of a packet
        rdy1_a = 1'b0;
        apply_stimulus(64'h0000_0000_4000_0003, 8'hFF, 1'b0, 22'h00_0E1, 1, st);
        check("t6_in_pkt", {95'd0, in_pkt_a}, 96'd1);
        in_a.tdata  = 64'h0000_0000_0000_0E02;
        in_a.tlast  = 1'b0;
        in_a.tvalid = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_p1_valid", {95'd0, p1_a.tvalid}, 96'd0);
        check("t6_p2_valid", {95'd0, p2_a.tvalid}, 96'd0);
        check("t6_in_pkt_rst", {95'd0, in_pkt_a}, 96'd0);
        check("t6_drop_rst", {80'd0, drop_cnt_a}, 96'd0);
        exp_q[0].delete();
        exp_q[1].delete();
        exp_drop    = 16'd0;
        in_a.tvalid = 1'b0;
        rdy1_a      = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(64'h0000_4444_0A00_0002, 8'hFF, 1'b1, 22'h00_0F1, 2, st);
        check("t6_cpl_stall", st, 0);
        check("t6_cpl_p2", {95'd0, p2_a.tvalid}, 96'd1);
        check("t6_cpl_not_p1", {95'd0, p1_a.tvalid}, 96'd0);
        repeat (3) @(posedge clk);
        #1;

        // every expected beat must have come out
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_q%0d", i), exp_q[i].size(), 96'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_demux.md
Name: rx_demux

Overview:
- Receive-side counterpart of the PCIe TX arbitration path.
- Accepts the single 64-bit AXIS RX TLP stream from the PCIe core and steers each whole TLP to one of two consumers:
  - port 1: requester/target logic (MRd/MWr/IO/Cfg).
  - port 2: completion consumer (Cpl/CplD/CplLk/CplDLk).
- Message TLPs are discarded, or forwarded to port 1 if configured.
- Routing is decided on the first beat and held for the whole packet. Each output has one registered stage.

Parameters:
- DROP_CNT_W, 16, width of the saturating dropped-TLP counter.
- ROUTE_MSG, 0, 0 = discard message TLPs; 1 = forward them to port 1.

Ports:
- clk  input  1  core user clock.
- sys_rst_n  input  1  asynchronous active-low reset.
- m_axis_rx_tdata  input  64  RX beat; first beat carries DW0 in [31:0] (fmt [30:29], type [28:24]).
- m_axis_rx_tkeep  input  8  byte enables.
- m_axis_rx_tlast  input  1  end of TLP.
- m_axis_rx_tvalid  input  1  beat valid.
- m_axis_rx_tuser  input  22  core sideband; forwarded unchanged.
- m_axis_rx_tready  output  1  beat accepted when tvalid&tready.
- m_axis_rx1_tdata/tkeep/tlast/tvalid/tuser  output  64/8/1/1/22  port 1 stream.
- m_axis_rx1_tready  input  1  port 1 ready.
- m_axis_rx2_tdata/tkeep/tlast/tvalid/tuser  output  64/8/1/1/22  port 2 stream.
- m_axis_rx2_tready  input  1  port 2 ready.
- drop_cnt  output  DROP_CNT_W  count of discarded TLPs.
- in_pkt  output  1  high between first beat and tlast beat (status).

Behaviour:
- Reset (sys_rst_n low, asynchronous):
  - All output valids 0; the data/keep/last/user registers are cleared to 0.
  - drop_cnt 0, in_pkt 0, state SOP.
  - Deassertion is synchronised by the surrounding reset logic; the block does not resynchronise it.
- Classification, evaluated only on a first beat (state SOP):
  - type[4:1]==4'b0101 → port 2 (completions).
  - type[4:3]==2'b10 → message: DROP if ROUTE_MSG=0, else port 1.
  - All other types → port 1.
- State machine:
  - SOP: on an accepted beat, latch the route into route_q. If tlast is set on that beat, stay in SOP; otherwise go to BODY.
  - BODY: route_q is held. On an accepted beat with tlast, go to SOP.
  - The route never changes mid-packet, whatever the header-like data in later beats.
- Output stage (per port):
  - One register (valid_q plus payload).
  - Port n can load when ~valid_q[n] | rxn_tready.
- Input ready:
  - m_axis_rx_tready = 1 when the selected route is DROP.
  - Otherwise m_axis_rx_tready = can-load of the selected port.
  - In SOP, the selected route is the combinational classification of the current beat. In BODY it is route_q.
  - Throughput: one beat per clock when the selected consumer keeps its ready high.
- Latency: an accepted beat appears on its port's output on the next clock edge (1 cycle).
- Output valid hold: valid_q[n] is set on load and cleared when rxn_tready=1 and no new load occurs. Payload is stable while valid and not ready (AXIS rule).
- Independence: the port not currently selected keeps draining its pending beat independently. Both ports may show valid in the same cycle, at most one beat each.
- DROP: beats are consumed and nothing is written to either port. drop_cnt increments once per dropped TLP, on its first beat, and saturates at all-ones with no wrap.
- in_pkt = (state==BODY).
- tvalid low: no state change. route_q is held across idle gaps inside a packet.
- Reset mid-packet: the partial packet is lost. Output registers are cleared with no tlast emitted. After reset the next beat is treated as a first beat. Consumers are reset by the same sys_rst_n.
- The block does no tkeep/length checking; a malformed packet is routed by its first beat only.

Test Plan:
- MWr header, 3 beats (first tdata[31:0]=32'h40000001, tlast on beat 3), both readies 1 → 3 beats on port 1 at cycles +1..+3 with identical data/keep/user; port 2 valid stays 0; tready held 1.
- CplD, first DW0=32'h4A000001, 2 beats; rx2_tready held 0 for 4 cycles then 1 → port 2 holds beat 1 stable; m_axis_rx_tready=0 while full; beat 2 follows one cycle after ready rises; port 1 untouched.
- Message DW0=32'h34000000 with ROUTE_MSG=0, 2 beats → tready=1 both cycles, no output valid, drop_cnt 0→1; repeat with ROUTE_MSG=1 → packet on port 1, drop_cnt 0.
- Back-to-back single-beat MRd (32'h00000001, tlast) then 2-beat Cpl, rx1_tready=0 → MRd parks on port 1 while the Cpl flows to port 2 without stall; port 1 releases when rx1_tready=1.
- BODY beat whose data equals 32'h4A000000 inside an MWr → still routed to port 1. Saturation: preload 2^DROP_CNT_W−1 drops, one more → drop_cnt stays 16'hFFFF.
- Assert sys_rst_n=0 mid-BODY → all valids 0 asynchronously, in_pkt=0. After release, the next beat (Cpl header) is routed to port 2.
